// File: rtl/reset_sequencer.sv
// reset_sequencer: filters PLL lock, then releases ordered stage resets with programmable spacing
module reset_sequencer #(
    parameter int N_LOCK        = 2,
    parameter int SETTLE_CYCLES = 100,
    parameter int STAGE_GAP     = 16,
    parameter int N_STAGES      = 3,
    parameter int W_CNT         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_LOCK-1:0]   pll_locked,
    input  logic                sw_rst_req,
    output logic [N_STAGES-1:0] rst_n_out,
    output logic                all_released,
    output logic [7:0]          lock_loss_count
);
    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_RELEASE, S_RUN} state_t;
    state_t              state_q, state_d;
    logic [N_LOCK-1:0]   sync1_q, sync2_q;
    logic [W_CNT-1:0]    cnt_q, cnt_d;
    logic [N_STAGES-1:0] out_d;
    logic                all_d;
    logic [7:0]          loss_d;
    logic                locked;
    assign locked = &sync2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q         <= '0;
            sync2_q         <= '0;
            state_q         <= S_WAIT;
            cnt_q           <= '0;
            rst_n_out       <= '0;
            all_released    <= 1'b0;
            lock_loss_count <= '0;
        end else begin
            sync1_q         <= pll_locked;
            sync2_q         <= sync1_q;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rst_n_out       <= out_d;
            all_released    <= all_d;
            lock_loss_count <= loss_d;
        end
    end
    // Outputs are shifted in as a thermometer code so stages can only rise in order
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = rst_n_out;
        all_d   = all_released;
        loss_d  = lock_loss_count;
        case (state_q)
            S_WAIT: begin
                if (locked) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (!locked) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (sw_rst_req) begin
                    cnt_d = '0;
                end else if (cnt_q == W_CNT'(SETTLE_CYCLES - 1)) begin
                    out_d   = N_STAGES'(1);
                    all_d   = (N_STAGES == 1);
                    state_d = (N_STAGES == 1) ? S_RUN : S_RELEASE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + W_CNT'(1);
                end
            end
            default: begin
                if (!locked) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    out_d   = '0;
                    all_d   = 1'b0;
                    loss_d  = (lock_loss_count == 8'hFF) ? lock_loss_count : lock_loss_count + 8'd1;
                end else if (sw_rst_req) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                    out_d   = '0;
                    all_d   = 1'b0;
                end else if (state_q == S_RELEASE) begin
                    if (cnt_q == W_CNT'(STAGE_GAP - 1)) begin
                        out_d   = (rst_n_out << 1) | N_STAGES'(1);
                        all_d   = &out_d;
                        state_d = (&out_d) ? S_RUN : S_RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + W_CNT'(1);
                    end
                end
            end
        endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed stimulus with a time-based release model checked every cycle
`timescale 1ns/1ps
module tb_reset_sequencer;
    localparam int S = 100;
    localparam int G = 16;
    localparam int N = 3;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   pll_locked;
    logic         sw_rst_req;
    logic [N-1:0] rst_n_out;
    logic         all_released;
    logic [7:0]   lock_loss_count;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    reset_sequencer #(
        .N_LOCK(2), .SETTLE_CYCLES(S), .STAGE_GAP(G), .N_STAGES(N), .W_CNT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_rst_req(sw_rst_req),
        .rst_n_out(rst_n_out), .all_released(all_released), .lock_loss_count(lock_loss_count)
    );
    always #5 clk = ~clk;
    // Model: a running sequence is described only by the edge its settle window started on
    int           edge_n;
    logic [1:0]   hist;
    bit           running;
    int           seq_start;
    int           m_loss;
    logic [N-1:0] m_out;
    bit           m_all;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n = 0; hist = 0; running = 0; seq_start = 0; m_loss = 0; m_out = 0; m_all = 0;
        end else begin
            bit lk;
            edge_n++;
            lk = hist[1];
            hist = {hist[0], &pll_locked};
            if (!running) begin
                if (lk) begin running = 1; seq_start = edge_n; end
            end else if (!lk) begin
                if (m_out != 0) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
                running = 0;
            end else if (sw_rst_req) begin
                seq_start = edge_n;
            end
            for (int k = 0; k < N; k++) m_out[k] = running && (edge_n - seq_start >= S + k * G);
            m_all = &m_out;
        end
    end
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            checks++;
            if (rst_n_out !== m_out || all_released !== m_all || lock_loss_count !== m_loss[7:0]) begin
                errors++;
                $display("FAIL cycle edge=%0d: got out=%b all=%b cnt=%0d expected out=%b all=%b cnt=%0d",
                         edge_n, rst_n_out, all_released, lock_loss_count, m_out, m_all, m_loss);
            end
        end
    end
    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic wait_bit(int k, output int e);
        e = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rst_n_out[k]) begin
                e = edge_n;
                return;
            end
        end
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
    initial begin
        int t0, e;
        rst_n = 1'b0; pll_locked = 2'b00; sw_rst_req = 1'b0;
        #1;
        check("reset_out", int'(rst_n_out), 0);
        check("reset_all", int'(all_released), 0);
        check("reset_cnt", int'(lock_loss_count), 0);
        tick(3);
        rst_n = 1'b1; chk_en = 1'b1;
        tick(3);
        sw_rst_req = 1'b1; tick(1); sw_rst_req = 1'b0;
        tick(2);
        check("wait_ignores_sw", int'(rst_n_out), 0);
        // Power-up sequence
        pll_locked = 2'b11; t0 = edge_n + 1;
        wait_bit(0, e); check("rise0", e - t0, 102);
        wait_bit(1, e); check("rise1", e - t0, 118);
        wait_bit(2, e); check("rise2", e - t0, 134);
        check("all_released", int'(all_released), 1);
        check("cnt_after_seq", int'(lock_loss_count), 0);
        tick(5);
        // Lock loss in RUN and relock
        pll_locked = 2'b01;
        tick(1); check("loss_L", int'(rst_n_out), 7);
        tick(1); check("loss_L1", int'(rst_n_out), 7);
        tick(1); check("loss_L2_out", int'(rst_n_out), 0);
        check("loss_L2_all", int'(all_released), 0);
        check("loss_cnt", int'(lock_loss_count), 1);
        pll_locked = 2'b11; t0 = edge_n + 1;
        wait_bit(0, e); check("relock_rise0", e - t0, 102);
        wait_bit(2, e); check("relock_rise2", e - t0, 134);
        tick(3);
        // Software reset in RUN
        sw_rst_req = 1'b1; t0 = edge_n + 1;
        tick(1); sw_rst_req = 1'b0;
        check("sw_out", int'(rst_n_out), 0);
        wait_bit(0, e); check("sw_rise0", e - t0, 100);
        wait_bit(2, e); check("sw_rise2", e - t0, 132);
        check("sw_cnt", int'(lock_loss_count), 1);
        // Glitch during settle
        pll_locked = 2'b00; tick(4);
        check("drop_cnt", int'(lock_loss_count), 2);
        pll_locked = 2'b11;
        tick(52);
        pll_locked = 2'b10;
        tick(1);
        pll_locked = 2'b11; t0 = edge_n + 1;
        wait_bit(0, e); check("glitch_rise0", e - t0, 102);
        check("glitch_cnt", int'(lock_loss_count), 2);
        // Asynchronous reset mid-release
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("async_out", int'(rst_n_out), 0);
        check("async_all", int'(all_released), 0);
        check("async_cnt", int'(lock_loss_count), 0);
        tick(2);
        rst_n = 1'b1; t0 = edge_n + 1;
        wait_bit(0, e); check("post_reset_rise0", e - t0, 102);
        // Saturation of lock-loss counter
        for (int i = 0; i < 300; i++) begin
            pll_locked = 2'b11;
            wait_bit(0, e);
            if (e < 0) check("sat_timeout", e, 0);
            pll_locked = 2'b00;
            tick(4);
        end
        check("sat_cnt", int'(lock_loss_count), 255);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
